note_sequencer: RTL

Sequencer that drives the triangle-wave player's `p_frequency` and `volume` inputs from a programmable note table. Each note has a linear attack ramp, a hold for a programmed duration, and a linear release ramp. All timing runs on sample ticks derived from the shared `m_sample_index` counter. Sits between the PS-side register/control path and `player_module`, in the `mclk` domain.

---
 rtl/synth_pkg.sv | 29 ++
 rtl/env_ramp.sv | 61 ++++++
 rtl/note_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared types for the synth voice path: sequencer states, note table entries
// and the sample-tick phase used by every voice.
package synth_pkg;

    localparam int NOTE_FREQ_BITS = 4;
    localparam int NOTE_VOL_BITS  = 8;
    localparam int NOTE_DUR_BITS  = 8;

    localparam logic [7:0] SAMPLE_TICK_IDX = 8'hFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ATTACK  = 3'd2,
        HOLD    = 3'd3,
        RELEASE = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic [NOTE_FREQ_BITS-1:0] freq;
        logic [NOTE_VOL_BITS-1:0]  vol;
        logic [NOTE_DUR_BITS-1:0]  dur;
    } note_entry_t;

    function automatic logic is_sample_tick(input logic [7:0] idx);
        return (idx == SAMPLE_TICK_IDX);
    endfunction

endpackage

// File: rtl/env_ramp.sv
// Saturating volume stepper: moves toward target on up, toward zero on down,
// one RAMP_STEP per sample tick.
module env_ramp
    import synth_pkg::*;
#(
    parameter int VOLUME_BITS = 8,
    parameter int RAMP_STEP   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stick,
    input  logic                   up,
    input  logic                   down,
    input  logic [VOLUME_BITS-1:0] target,
    output logic [VOLUME_BITS-1:0] volume,
    output logic                   at_target
);

    localparam logic [VOLUME_BITS:0] STEP_W = (VOLUME_BITS+1)'(RAMP_STEP);

    logic [VOLUME_BITS-1:0] volume_q, volume_d;
    logic [VOLUME_BITS:0]   vol_ext;
    logic [VOLUME_BITS:0]   up_sum;
    logic [VOLUME_BITS:0]   dn_diff;

    // Next volume: one extra bit of headroom so neither direction can wrap.
    always_comb begin
        vol_ext  = {1'b0, volume_q};
        up_sum   = vol_ext + STEP_W;
        dn_diff  = vol_ext - STEP_W;
        volume_d = volume_q;
        if (stick && up) begin
            if (up_sum > {1'b0, target}) begin
                volume_d = target;
            end else begin
                volume_d = up_sum[VOLUME_BITS-1:0];
            end
        end else if (stick && down) begin
            if (vol_ext < STEP_W) begin
                volume_d = '0;
            end else begin
                volume_d = dn_diff[VOLUME_BITS-1:0];
            end
        end else begin
            volume_d = volume_q;
        end
    end

    // Volume register; reset silences the voice immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            volume_q <= '0;
        end else begin
            volume_q <= volume_d;
        end
    end

    assign volume    = volume_q;
    assign at_target = (volume_q == target);

endmodule

// File: rtl/note_sequencer.sv
// Plays a programmable note table into the triangle player: each note ramps up,
// holds for its duration in prescaled sample ticks, then ramps back to silence.
module note_sequencer
    import synth_pkg::*;
#(
    parameter int SEQ_LEN       = 16,
    parameter int VOLUME_BITS   = 8,
    parameter int FREQ_RES_BITS = 4,
    parameter int DUR_BITS      = 8,
    parameter int PRESCALE      = 256,
    parameter int RAMP_STEP     = 8
) (
    input  logic                       mclk,
    input  logic                       rst,
    input  logic [7:0]                 m_sample_index,
    input  logic                       wr_en,
    input  logic [$clog2(SEQ_LEN)-1:0] wr_addr,
    input  logic [FREQ_RES_BITS-1:0]   wr_freq,
    input  logic [VOLUME_BITS-1:0]     wr_vol,
    input  logic [DUR_BITS-1:0]        wr_dur,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop_en,
    output logic [FREQ_RES_BITS-1:0]   p_frequency,
    output logic [VOLUME_BITS-1:0]     volume,
    output logic                       busy,
    output logic [$clog2(SEQ_LEN)-1:0] step_index,
    output logic                       done
);

    localparam int AW = $clog2(SEQ_LEN);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    seq_state_t                state_q, state_d;
    note_entry_t               notes_q [SEQ_LEN];
    note_entry_t               notes_d [SEQ_LEN];
    note_entry_t               entry;
    logic [AW-1:0]             step_index_q, step_index_d;
    logic [FREQ_RES_BITS-1:0]  p_frequency_q, p_frequency_d;
    logic [VOLUME_BITS-1:0]    cur_vol_q, cur_vol_d;
    logic [DUR_BITS-1:0]       cur_dur_q, cur_dur_d;
    logic [PW-1:0]             presc_q, presc_d;
    logic [DUR_BITS-1:0]       dur_cnt_q, dur_cnt_d;
    logic                      stop_pend_q, stop_pend_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      stick;
    logic                      ramp_up;
    logic                      ramp_down;
    logic                      at_target;
    logic [VOLUME_BITS-1:0]    env_volume;

    assign stick = is_sample_tick(m_sample_index);
    assign entry = notes_q[step_index_q];

    // Note table write port.
    always_comb begin
        notes_d = notes_q;
        if (wr_en) begin
            notes_d[wr_addr].freq = wr_freq;
            notes_d[wr_addr].vol  = wr_vol;
            notes_d[wr_addr].dur  = wr_dur;
        end else begin
            notes_d = notes_q;
        end
    end

    // Note table storage.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SEQ_LEN; i++) begin
                notes_q[i] <= '0;
            end
        end else begin
            notes_q <= notes_d;
        end
    end

    // Sequencer next-state and datapath control.
    always_comb begin
        state_d       = state_q;
        step_index_d  = step_index_q;
        p_frequency_d = p_frequency_q;
        cur_vol_d     = cur_vol_q;
        cur_dur_d     = cur_dur_q;
        presc_d       = presc_q;
        dur_cnt_d     = dur_cnt_q;
        stop_pend_d   = stop_pend_q;
        done_d        = 1'b0;
        ramp_up       = 1'b0;
        ramp_down     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d      = LOAD;
                    step_index_d = '0;
                    stop_pend_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                cur_vol_d   = entry.vol;
                cur_dur_d   = entry.dur;
                stop_pend_d = stop_pend_q | stop;
                if (entry.dur != '0) begin
                    p_frequency_d = entry.freq;
                    state_d       = ATTACK;
                end else if (loop_en && (step_index_q != '0)) begin
                    // Entry 0 is never re-looped onto itself, so an empty table halts.
                    step_index_d = '0;
                    state_d      = LOAD;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            ATTACK: begin
                ramp_up = 1'b1;
                if (stop || stop_pend_q) begin
                    stop_pend_d = 1'b1;
                    state_d     = RELEASE;
                end else if (at_target) begin
                    state_d   = HOLD;
                    presc_d   = '0;
                    dur_cnt_d = '0;
                end else begin
                    state_d = ATTACK;
                end
            end
            HOLD: begin
                if (stop || stop_pend_q) begin
                    stop_pend_d = 1'b1;
                    state_d     = RELEASE;
                end else if (dur_cnt_q == cur_dur_q) begin
                    state_d = RELEASE;
                end else if (stick) begin
                    if (presc_q == PW'(PRESCALE - 1)) begin
                        presc_d   = '0;
                        dur_cnt_d = dur_cnt_q + DUR_BITS'(1'b1);
                    end else begin
                        presc_d = presc_q + PW'(1'b1);
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            RELEASE: begin
                ramp_down   = 1'b1;
                stop_pend_d = stop_pend_q | stop;
                if (env_volume == '0) begin
                    if (stop_pend_q || stop) begin
                        state_d     = IDLE;
                        done_d      = 1'b1;
                        stop_pend_d = 1'b0;
                    end else begin
                        step_index_d = step_index_q + AW'(1'b1);
                        state_d      = LOAD;
                    end
                end else begin
                    state_d = RELEASE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            step_index_q  <= '0;
            p_frequency_q <= '0;
            cur_vol_q     <= '0;
            cur_dur_q     <= '0;
            presc_q       <= '0;
            dur_cnt_q     <= '0;
            stop_pend_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_index_q  <= step_index_d;
            p_frequency_q <= p_frequency_d;
            cur_vol_q     <= cur_vol_d;
            cur_dur_q     <= cur_dur_d;
            presc_q       <= presc_d;
            dur_cnt_q     <= dur_cnt_d;
            stop_pend_q   <= stop_pend_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    env_ramp #(
        .VOLUME_BITS (VOLUME_BITS),
        .RAMP_STEP   (RAMP_STEP)
    ) u_env_ramp (
        .clk       (mclk),
        .rst       (rst),
        .stick     (stick),
        .up        (ramp_up),
        .down      (ramp_down),
        .target    (cur_vol_q),
        .volume    (env_volume),
        .at_target (at_target)
    );

    assign p_frequency = p_frequency_q;
    assign volume      = env_volume;
    assign busy        = busy_q;
    assign step_index  = step_index_q;
    assign done        = done_q;

endmodule
